hazard_scoreboard: RTL and testbench

//  Parametrised ID-stage hazard unit for the RV32I pipeline, next generation of the register-read decoder.

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard unit: decodes the ID instruction and tracks in-flight writers.
// Raises a zero-latency stall in no-forwarding or load-use-only forwarding mode.
module hazard_scoreboard #(
  parameter int DEPTH       = 3,
  parameter int FWD         = 0,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             id_valid,
  input  logic             flush,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             re1,
  output logic             re2,
  output logic             we,
  output logic             stall,
  output logic [3:0]       inflight,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0]       opc;
  logic             we_raw;
  logic             is_load;
  logic             issue;
  logic             hit1;
  logic             hit2;
  logic             hz1;
  logic             hz2;
  logic [DEPTH-1:0] sh_v;
  logic [DEPTH-1:0] sh_ld;
  logic [4:0]       sh_rd [DEPTH];
  logic [DEPTH-1:0] nxt_v;
  logic [DEPTH-1:0] nxt_ld;
  logic [4:0]       nxt_rd [DEPTH];
  logic [3:0]       nxt_cnt;
  logic             unused_bits;

  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];
  assign opc = inst[6:2];
  // The WB entry retires without being compared, and funct7/quadrant bits are never decoded.
  assign unused_bits = ^{inst[31:25], inst[1:0], sh_v[DEPTH-1], sh_ld[DEPTH-1], sh_rd[DEPTH-1]};

  always_comb begin
    re1     = 1'b0;
    re2     = 1'b0;
    we_raw  = 1'b0;
    is_load = 1'b0;
    case (opc)
      5'b01100: begin re1 = 1'b1; re2 = 1'b1; we_raw = 1'b1; end
      5'b00100: begin re1 = 1'b1; we_raw = 1'b1; end
      5'b00000: begin re1 = 1'b1; we_raw = 1'b1; is_load = 1'b1; end
      5'b01000: begin re1 = 1'b1; re2 = 1'b1; end
      5'b11000: begin re1 = 1'b1; re2 = 1'b1; end
      5'b01101, 5'b00101, 5'b11011: we_raw = 1'b1;
      5'b11001: begin re1 = 1'b1; we_raw = 1'b1; end
      default: ;
    endcase
  end

  assign we = we_raw & (rd != 5'd0);

  // ID: compare sources against the pre-WB shadow entries
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (FWD == 0 || (i == 0 && sh_ld[i])) begin
        if (sh_v[i] && sh_rd[i] == rs1) hit1 = 1'b1;
        if (sh_v[i] && sh_rd[i] == rs2) hit2 = 1'b1;
      end
    end
  end

  assign hz1   = re1 & (rs1 != 5'd0) & hit1;
  assign hz2   = re2 & (rs2 != 5'd0) & hit2;
  assign stall = id_valid & ~flush & (hz1 | hz2);
  assign issue = id_valid & ~stall & ~flush;

  // EX..WB: shadow shift, flush kills the youngest FLUSH_DEPTH-1 entries in transit
  always_comb begin
    nxt_v  = '0;
    nxt_ld = '0;
    for (int i = 0; i < DEPTH; i++) nxt_rd[i] = '0;
    nxt_v[0]  = issue & we;
    nxt_rd[0] = rd;
    nxt_ld[0] = is_load;
    for (int i = 1; i < DEPTH; i++) begin
      nxt_v[i]  = sh_v[i-1] & ~(flush & (i < FLUSH_DEPTH));
      nxt_rd[i] = sh_rd[i-1];
      nxt_ld[i] = sh_ld[i-1];
    end
    nxt_cnt = '0;
    for (int i = 0; i < DEPTH; i++) nxt_cnt = nxt_cnt + 4'(nxt_v[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_v         <= '0;
      sh_ld        <= '0;
      for (int i = 0; i < DEPTH; i++) sh_rd[i] <= '0;
      inflight     <= '0;
      stall_cycles <= '0;
    end else begin
      sh_v     <= nxt_v;
      sh_ld    <= nxt_ld;
      for (int i = 0; i < DEPTH; i++) sh_rd[i] <= nxt_rd[i];
      inflight <= nxt_cnt;
      if (stall && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations against an age-based writer-pool model.
module tb_hazard_scoreboard;
  localparam int A_DEPTH = 3, A_FWD = 0, A_FD = 2, A_CW = 4;
  localparam int B_DEPTH = 4, B_FWD = 1, B_FD = 3, B_CW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h0;
  logic        id_valid = 1'b0;
  logic        flush = 1'b0;

  logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
  logic a_re1, a_re2, a_we, a_stall, b_re1, b_re2, b_we, b_stall;
  logic [3:0] a_inflight, b_inflight;
  logic [A_CW-1:0] a_sc;
  logic [B_CW-1:0] b_sc;

  hazard_scoreboard #(.DEPTH(A_DEPTH), .FWD(A_FWD), .FLUSH_DEPTH(A_FD), .CNT_W(A_CW)) dut_a (
    .clk(clk), .rst(rst), .inst(inst), .id_valid(id_valid), .flush(flush),
    .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .re1(a_re1), .re2(a_re2), .we(a_we),
    .stall(a_stall), .inflight(a_inflight), .stall_cycles(a_sc));

  hazard_scoreboard #(.DEPTH(B_DEPTH), .FWD(B_FWD), .FLUSH_DEPTH(B_FD), .CNT_W(B_CW)) dut_b (
    .clk(clk), .rst(rst), .inst(inst), .id_valid(id_valid), .flush(flush),
    .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .re1(b_re1), .re2(b_re2), .we(b_we),
    .stall(b_stall), .inflight(b_inflight), .stall_cycles(b_sc));

  always #5 clk = ~clk;

  // Model: an unordered pool of writers, each carrying its age in cycles since issue.
  typedef struct { bit live; logic [4:0] rd; bit ld; int age; } wr_t;
  wr_t pool [2][8];
  int  mcnt [2];
  bit  exp_st [2];
  int  n_tests = 0;
  int  n_fail = 0;
  logic obs_stall [2];
  logic obs_we [2];
  logic obs_re1 [2];
  logic obs_re2 [2];
  int   obs_inf [2];
  int   obs_sc [2];

  function automatic int pdepth(int m); return (m == 0) ? A_DEPTH : B_DEPTH; endfunction
  function automatic int pfwd(int m);   return (m == 0) ? A_FWD : B_FWD; endfunction
  function automatic int pfd(int m);    return (m == 0) ? A_FD : B_FD; endfunction
  function automatic int pmax(int m);   return (m == 0) ? (1 << A_CW) - 1 : (1 << B_CW) - 1; endfunction

  // {re1, re2, we, is_load} from the opcode table
  function automatic logic [3:0] dec(input logic [31:0] i);
    logic [4:0] op;
    logic [3:0] r;
    op = i[6:2];
    r = 4'b0000;
    if (op == 5'b01100) r = 4'b1110;
    else if (op == 5'b00100) r = 4'b1010;
    else if (op == 5'b00000) r = 4'b1011;
    else if (op == 5'b01000 || op == 5'b11000) r = 4'b1100;
    else if (op == 5'b01101 || op == 5'b00101 || op == 5'b11011) r = 4'b0010;
    else if (op == 5'b11001) r = 4'b1010;
    if (i[11:7] == 5'd0) r[1] = 1'b0;
    return r;
  endfunction

  function automatic bit m_stall(int m, logic [31:0] i, logic v, logic f, logic r);
    logic [3:0] d;
    logic [4:0] s1, s2;
    bit h;
    d = dec(i);
    s1 = i[19:15];
    s2 = i[24:20];
    h = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (pool[m][s].live) begin
        bit near;
        if (pfwd(m) == 0) near = (pool[m][s].age <= pdepth(m) - 2);
        else near = (pool[m][s].age == 0) && pool[m][s].ld;
        if (near && ((d[3] && s1 != 5'd0 && pool[m][s].rd == s1) ||
                     (d[2] && s2 != 5'd0 && pool[m][s].rd == s2))) h = 1'b1;
      end
    end
    return v && !f && !r && h;
  endfunction

  function automatic int m_live(int m);
    int c;
    c = 0;
    for (int s = 0; s < 8; s++) if (pool[m][s].live) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0;
      for (int s = 0; s < 8; s++) begin
        pool[m][s].live = 1'b0; pool[m][s].rd = 5'd0; pool[m][s].ld = 1'b0; pool[m][s].age = 0;
      end
    end
  endtask

  task automatic m_edge(int m, logic [31:0] i, logic v, logic f, bit st);
    logic [3:0] d;
    bit done;
    d = dec(i);
    done = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (pool[m][s].live) begin
        if (f && pool[m][s].age < pfd(m) - 1) pool[m][s].live = 1'b0;
        else begin
          pool[m][s].age++;
          if (pool[m][s].age >= pdepth(m)) pool[m][s].live = 1'b0;
        end
      end
    end
    if (v && !st && !f && d[1]) begin
      for (int s = 0; s < 8; s++) begin
        if (!done && !pool[m][s].live) begin
          pool[m][s].live = 1'b1; pool[m][s].rd = i[11:7]; pool[m][s].ld = d[0]; pool[m][s].age = 0;
          done = 1'b1;
        end
      end
    end
    if (st && mcnt[m] < pmax(m)) mcnt[m]++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] d;
    d = dec(inst);
    exp_st[0] = m_stall(0, inst, id_valid, flush, rst);
    exp_st[1] = m_stall(1, inst, id_valid, flush, rst);
    chk("a_rs1", 32'(a_rs1), 32'(inst[19:15]));
    chk("a_rs2", 32'(a_rs2), 32'(inst[24:20]));
    chk("a_rd", 32'(a_rd), 32'(inst[11:7]));
    chk("a_re1", 32'(a_re1), 32'(d[3]));
    chk("a_re2", 32'(a_re2), 32'(d[2]));
    chk("a_we", 32'(a_we), 32'(d[1]));
    chk("a_stall", 32'(a_stall), 32'(exp_st[0]));
    chk("a_inflight", 32'(a_inflight), 32'(m_live(0)));
    chk("a_stall_cycles", 32'(a_sc), 32'(mcnt[0]));
    chk("b_rs1", 32'(b_rs1), 32'(inst[19:15]));
    chk("b_rs2", 32'(b_rs2), 32'(inst[24:20]));
    chk("b_rd", 32'(b_rd), 32'(inst[11:7]));
    chk("b_re1", 32'(b_re1), 32'(d[3]));
    chk("b_re2", 32'(b_re2), 32'(d[2]));
    chk("b_we", 32'(b_we), 32'(d[1]));
    chk("b_stall", 32'(b_stall), 32'(exp_st[1]));
    chk("b_inflight", 32'(b_inflight), 32'(m_live(1)));
    chk("b_stall_cycles", 32'(b_sc), 32'(mcnt[1]));
    obs_stall[0] = a_stall; obs_stall[1] = b_stall;
    obs_we[0] = a_we;       obs_we[1] = b_we;
    obs_re1[0] = a_re1;     obs_re1[1] = b_re1;
    obs_re2[0] = a_re2;     obs_re2[1] = b_re2;
    obs_inf[0] = 32'(a_inflight); obs_inf[1] = 32'(b_inflight);
    obs_sc[0] = 32'(a_sc);  obs_sc[1] = 32'(b_sc);
  endtask

  // Entered one time unit after a rising edge; returns one time unit after the next.
  task automatic cycle(input logic [31:0] i, input logic v, input logic f);
    inst = i; id_valid = v; flush = f;
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_edge(0, inst, id_valid, flush, exp_st[0]);
    m_edge(1, inst, id_valid, flush, exp_st[1]);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 m_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] r_add(logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(logic [4:0] d, logic [4:0] s1);
    return {12'd1, s1, 3'b000, d, 7'b0010011};
  endfunction
  function automatic logic [31:0] i_lw(logic [4:0] d, logic [4:0] s1);
    return {12'd0, s1, 3'b010, d, 7'b0000011};
  endfunction
  function automatic logic [31:0] s_sw(logic [4:0] s2, logic [4:0] s1);
    return {7'b0, s2, s1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    r = $urandom;
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b1100011;
      5: r[6:0] = 7'b0110111;
      6: r[6:0] = 7'b0010111;
      7: r[6:0] = 7'b1101111;
      8: r[6:0] = 7'b1100111;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    m_reset();
    #2 check_all();
    chk("reset_inflight_a", 32'(a_inflight), 32'd0);
    chk("reset_stall_cycles_a", 32'(a_sc), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: back-to-back RAW without forwarding
    cycle(r_add(5, 1, 2), 1'b1, 1'b0);
    cycle(r_add(6, 5, 1), 1'b1, 1'b0);
    chk("t1_stall_c1", 32'(obs_stall[0]), 32'd1);
    cycle(r_add(6, 5, 1), 1'b1, 1'b0);
    chk("t1_stall_c2", 32'(obs_stall[0]), 32'd1);
    cycle(r_add(6, 5, 1), 1'b1, 1'b0);
    chk("t1_stall_c3", 32'(obs_stall[0]), 32'd0);
    chk("t1_stall_cycles", 32'(obs_sc[0]), 32'd2);
    chk("t1_no_fwd_stall_b", 32'(obs_stall[1]), 32'd0);
    drain(5);

    // T2: store reads rs2; branch on x0 and LUI
    cycle(r_add(5, 1, 2), 1'b1, 1'b0);
    cycle(s_sw(5, 3), 1'b1, 1'b0);
    chk("t2_sw_re2", 32'(obs_re2[0]), 32'd1);
    chk("t2_sw_stall1", 32'(obs_stall[0]), 32'd1);
    cycle(s_sw(5, 3), 1'b1, 1'b0);
    chk("t2_sw_stall2", 32'(obs_stall[0]), 32'd1);
    cycle(s_sw(5, 3), 1'b1, 1'b0);
    chk("t2_sw_stall3", 32'(obs_stall[0]), 32'd0);
    cycle({7'b0, 5'd0, 5'd0, 3'b000, 5'd0, 7'b1100011}, 1'b1, 1'b0);
    chk("t2_beq_stall", 32'(obs_stall[0]), 32'd0);
    cycle({20'h12345, 5'd7, 7'b0110111}, 1'b1, 1'b0);
    chk("t2_lui_re1", 32'(obs_re1[0]), 32'd0);
    chk("t2_lui_re2", 32'(obs_re2[0]), 32'd0);
    drain(5);

    // T3: load-use with forwarding
    cycle(i_lw(5, 1), 1'b1, 1'b0);
    cycle(r_add(6, 5, 0), 1'b1, 1'b0);
    chk("t3_loaduse_stall1", 32'(obs_stall[1]), 32'd1);
    cycle(r_add(6, 5, 0), 1'b1, 1'b0);
    chk("t3_loaduse_stall2", 32'(obs_stall[1]), 32'd0);
    drain(5);
    cycle(i_addi(5, 1), 1'b1, 1'b0);
    cycle(r_add(6, 5, 0), 1'b1, 1'b0);
    chk("t3_alu_fwd_stall", 32'(obs_stall[1]), 32'd0);
    drain(5);

    // T4: x0 destination is never tracked
    cycle(i_addi(0, 1), 1'b1, 1'b0);
    chk("t4_we_x0", 32'(obs_we[0]), 32'd0);
    cycle(r_add(6, 0, 0), 1'b1, 1'b0);
    chk("t4_stall", 32'(obs_stall[0]), 32'd0);
    chk("t4_inflight", 32'(obs_inf[0]), 32'd0);
    drain(5);

    // T5: flush kills the youngest writer
    cycle(r_add(5, 1, 2), 1'b1, 1'b0);
    cycle(r_add(6, 5, 1), 1'b1, 1'b1);
    chk("t5_flush_stall", 32'(obs_stall[0]), 32'd0);
    cycle(r_add(6, 5, 1), 1'b1, 1'b0);
    chk("t5_inflight_a", 32'(obs_inf[0]), 32'd0);
    chk("t5_inflight_b", 32'(obs_inf[1]), 32'd0);
    chk("t5_stall_after", 32'(obs_stall[0]), 32'd0);
    drain(5);

    // T6: reset in the middle of a stall
    cycle(r_add(5, 1, 2), 1'b1, 1'b0);
    cycle(r_add(6, 5, 1), 1'b1, 1'b0);
    chk("t6_pre_stall", 32'(obs_stall[0]), 32'd1);
    do_reset();
    chk("t6_rst_stall", 32'(obs_stall[0]), 32'd0);
    chk("t6_rst_inflight", 32'(obs_inf[0]), 32'd0);
    chk("t6_rst_stall_cycles", 32'(obs_sc[0]), 32'd0);
    cycle(r_add(6, 5, 1), 1'b1, 1'b0);
    chk("t6_reissue_stall", 32'(obs_stall[0]), 32'd0);
    drain(5);

    // T7: 20 stall cycles saturate a 4-bit counter
    repeat (10) begin
      cycle(r_add(5, 1, 2), 1'b1, 1'b0);
      repeat (3) cycle(r_add(6, 5, 1), 1'b1, 1'b0);
    end
    cycle(32'h0, 1'b0, 1'b0);
    chk("t7_saturate", 32'(obs_sc[0]), 32'd15);

    // Random traffic with occasional flush and asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(rnd_inst(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
